// File: rtl/wb_regfile_unit.sv
// -----------------------------------------------------------------------------
// wb_regfile_unit
//
// Write-back stage and architectural integer register file (x0..x31).
// Commits the memory-access stage result every cycle, serves two decode-stage
// operand reads with same-cycle write-through forwarding, provides an
// unforwarded debug read port, a registered commit-trace record and optional
// 64-bit performance counters.
//
// Optional feature macro: WB_PERF_CNT_EN
//   defined   : o_cycle counts rising edges since reset, o_wb_count counts
//               commits (i_mem_rd != 0); both wrap at 64 bits.
//   undefined : no counter flops; o_cycle and o_wb_count are tied to 0.
//
// Ports:
//   clk             in   system clock, rising-edge active
//   rstn            in   asynchronous active-low reset
//   i_mem_rd        in   destination register (0 = no write)
//   i_mem_res       in   result to commit to i_mem_rd
//   i_dec_rs1/rs2   in   decode read addresses
//   o_dec_rs1/2_data out decode operands, combinational, forwarded
//   i_dbg_addr      in   debug read address
//   o_dbg_data      out  architectural value, combinational, not forwarded
//   o_trace_valid   out  1 for one cycle after each commit
//   o_trace_rd      out  rd of the last commit
//   o_trace_res     out  value of the last commit
//   o_cycle         out  cycle counter (0 unless WB_PERF_CNT_EN)
//   o_wb_count      out  commit counter (0 unless WB_PERF_CNT_EN)
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module wb_regfile_unit #(
  parameter int NREG = 32,
  parameter int XLEN = `XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [4:0]      i_mem_rd,
  input  logic [XLEN-1:0] i_mem_res,
  input  logic [4:0]      i_dec_rs1,
  input  logic [4:0]      i_dec_rs2,
  output logic [XLEN-1:0] o_dec_rs1_data,
  output logic [XLEN-1:0] o_dec_rs2_data,
  input  logic [4:0]      i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data,
  output logic            o_trace_valid,
  output logic [4:0]      o_trace_rd,
  output logic [XLEN-1:0] o_trace_res,
  output logic [63:0]     o_cycle,
  output logic [63:0]     o_wb_count
);

  // x0 has no storage; it reads as zero everywhere.
  logic [XLEN-1:0] r_regs [1:NREG-1];

  logic            w_wr_en;
  logic [XLEN-1:0] w_rs1_arch;
  logic [XLEN-1:0] w_rs2_arch;
  logic            w_rs1_fwd;
  logic            w_rs2_fwd;

  logic            r_trace_valid_p1;
  logic [4:0]      r_trace_rd_p1;
  logic [XLEN-1:0] r_trace_res_p1;

  assign w_wr_en = (i_mem_rd != 5'd0);

  // Architectural read: x0 returns zero, otherwise the stored value.
  function automatic logic [XLEN-1:0] arch_read(input logic [4:0] addr,
                                                input logic [XLEN-1:0] val);
    if (addr == 5'd0) return '0;
    return val;
  endfunction

  // Forward only when the in-flight commit actually writes (rd != 0).
  function automatic logic fwd_hit(input logic [4:0] rs, input logic [4:0] rd);
    return (rs != 5'd0) && (rs == rd);
  endfunction

  // ---- commit (stage boundary: memory-access -> architectural state) ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_mem_rd] <= i_mem_res;
    end
  end

  // ---- decode and debug reads (combinational) ----
  always_comb begin
    w_rs1_arch = '0;
    w_rs2_arch = '0;
    o_dbg_data = '0;
    if (i_dec_rs1 != 5'd0) w_rs1_arch = arch_read(i_dec_rs1, r_regs[i_dec_rs1]);
    if (i_dec_rs2 != 5'd0) w_rs2_arch = arch_read(i_dec_rs2, r_regs[i_dec_rs2]);
    if (i_dbg_addr != 5'd0) o_dbg_data = arch_read(i_dbg_addr, r_regs[i_dbg_addr]);
  end

  assign w_rs1_fwd = fwd_hit(i_dec_rs1, i_mem_rd);
  assign w_rs2_fwd = fwd_hit(i_dec_rs2, i_mem_rd);

  assign o_dec_rs1_data = w_rs1_fwd ? i_mem_res : w_rs1_arch;
  assign o_dec_rs2_data = w_rs2_fwd ? i_mem_res : w_rs2_arch;

  // ---- trace record (stage boundary: commit -> trace p1) ----
  // Payload holds across idle cycles so the last commit stays observable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_trace_valid_p1 <= 1'b0;
      r_trace_rd_p1    <= 5'd0;
      r_trace_res_p1   <= '0;
    end else begin
      r_trace_valid_p1 <= w_wr_en;
      if (w_wr_en) begin
        r_trace_rd_p1  <= i_mem_rd;
        r_trace_res_p1 <= i_mem_res;
      end
    end
  end

  assign o_trace_valid = r_trace_valid_p1;
  assign o_trace_rd    = r_trace_rd_p1;
  assign o_trace_res   = r_trace_res_p1;

`ifdef WB_PERF_CNT_EN
  // ---- performance counters (free-running, wrap silently at 2^64) ----
  logic [63:0] r_cycle;
  logic [63:0] r_wb_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cycle    <= 64'd0;
      r_wb_count <= 64'd0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_wr_en) r_wb_count <= r_wb_count + 64'd1;
    end
  end

  assign o_cycle    = r_cycle;
  assign o_wb_count = r_wb_count;
`else
  assign o_cycle    = 64'd0;
  assign o_wb_count = 64'd0;
`endif

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench for wb_regfile_unit: stimulus pushes expectations tagged
// with the cycle at which they must hold; a negedge monitor pops and compares.
module tb_wb_regfile_unit;

  localparam int SIG_RS1  = 0;
  localparam int SIG_RS2  = 1;
  localparam int SIG_DBG  = 2;
  localparam int SIG_TV   = 3;
  localparam int SIG_TRD  = 4;
  localparam int SIG_TRES = 5;
  localparam int SIG_CYC  = 6;
  localparam int SIG_WBC  = 7;

  logic        clk;
  logic        rstn;
  logic [4:0]  i_mem_rd;
  logic [31:0] i_mem_res;
  logic [4:0]  i_dec_rs1;
  logic [4:0]  i_dec_rs2;
  logic [31:0] o_dec_rs1_data;
  logic [31:0] o_dec_rs2_data;
  logic [4:0]  i_dbg_addr;
  logic [31:0] o_dbg_data;
  logic        o_trace_valid;
  logic [4:0]  o_trace_rd;
  logic [31:0] o_trace_res;
  logic [63:0] o_cycle;
  logic [63:0] o_wb_count;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          cyc;
  int          checks;
  int          failures;
  logic [63:0] m_cycle;
  logic [63:0] m_wb;

  wb_regfile_unit dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_mem_rd       (i_mem_rd),
    .i_mem_res      (i_mem_res),
    .i_dec_rs1      (i_dec_rs1),
    .i_dec_rs2      (i_dec_rs2),
    .o_dec_rs1_data (o_dec_rs1_data),
    .o_dec_rs2_data (o_dec_rs2_data),
    .i_dbg_addr     (i_dbg_addr),
    .o_dbg_data     (o_dbg_data),
    .o_trace_valid  (o_trace_valid),
    .o_trace_rd     (o_trace_rd),
    .o_trace_res    (o_trace_res),
    .o_cycle        (o_cycle),
    .o_wb_count     (o_wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      SIG_RS1:  return "rs1_data";
      SIG_RS2:  return "rs2_data";
      SIG_DBG:  return "dbg_data";
      SIG_TV:   return "trace_valid";
      SIG_TRD:  return "trace_rd";
      SIG_TRES: return "trace_res";
      SIG_CYC:  return "cycle";
      default:  return "wb_count";
    endcase
  endfunction

  function automatic logic [63:0] sample(input int s);
    case (s)
      SIG_RS1:  return {32'd0, o_dec_rs1_data};
      SIG_RS2:  return {32'd0, o_dec_rs2_data};
      SIG_DBG:  return {32'd0, o_dbg_data};
      SIG_TV:   return {63'd0, o_trace_valid};
      SIG_TRD:  return {59'd0, o_trace_rd};
      SIG_TRES: return {32'd0, o_trace_res};
      SIG_CYC:  return o_cycle;
      default:  return o_wb_count;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        logic [63:0] act;
        act = sample(sbq[i].sig);
        checks = checks + 1;
        if (act !== sbq[i].v) begin
          failures = failures + 1;
          $display("FAIL %s cyc=%0d got=%h expected=%h",
                   sig_name(sbq[i].sig), cyc, act, sbq[i].v);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic expect_at(input int dc, input int s, input logic [63:0] v);
    exp_t e;
    e.cyc = cyc + dc;
    e.sig = s;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic expect_trace(input logic v, input logic [4:0] rd, input logic [31:0] res);
    expect_at(1, SIG_TV, {63'd0, v});
    expect_at(1, SIG_TRD, {59'd0, rd});
    expect_at(1, SIG_TRES, {32'd0, res});
  endtask

  // Advance one edge (committing the previous inputs), then apply new inputs.
  task automatic drive(input logic [4:0] rd, input logic [31:0] res,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] dbg);
    logic [4:0] prev_rd;
    prev_rd = i_mem_rd;
    @(posedge clk);
    if (rstn) begin
      m_cycle = m_cycle + 64'd1;
      if (prev_rd != 5'd0) m_wb = m_wb + 64'd1;
    end
    #1;
    i_mem_rd   = rd;
    i_mem_res  = res;
    i_dec_rs1  = rs1;
    i_dec_rs2  = rs2;
    i_dbg_addr = dbg;
`ifdef WB_PERF_CNT_EN
    expect_at(0, SIG_CYC, m_cycle);
    expect_at(0, SIG_WBC, m_wb);
`else
    expect_at(0, SIG_CYC, 64'd0);
    expect_at(0, SIG_WBC, 64'd0);
`endif
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    m_cycle = 64'd0; m_wb = 64'd0;
    rstn = 1'b0;
    i_mem_rd = 5'd5; i_mem_res = 32'hDEADBEEF;
    i_dec_rs1 = 5'd0; i_dec_rs2 = 5'd0; i_dbg_addr = 5'd5;

    // Reset held 3 cycles with a pending write to x5: nothing commits.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_at(0, SIG_DBG, 64'd0);
      expect_at(0, SIG_TV, 64'd0);
      expect_at(0, SIG_TRES, 64'd0);
      expect_at(0, SIG_CYC, 64'd0);
      expect_at(0, SIG_WBC, 64'd0);
    end
    rstn = 1'b1;
    expect_at(0, SIG_DBG, 64'd0);
    expect_at(1, SIG_DBG, 64'hDEADBEEF);
    expect_trace(1'b1, 5'd5, 32'hDEADBEEF);

    // x0 protection
    drive(5'd0, 32'h12345678, 5'd0, 5'd0, 5'd5);
    expect_at(0, SIG_RS1, 64'd0);
    expect_at(0, SIG_RS2, 64'd0);
    expect_at(0, SIG_DBG, 64'hDEADBEEF);
    expect_trace(1'b0, 5'd5, 32'hDEADBEEF);
    drive(5'd0, 32'h0, 5'd0, 5'd5, 5'd0);
    expect_at(0, SIG_RS1, 64'd0);
    expect_at(0, SIG_RS2, 64'hDEADBEEF);
    expect_at(0, SIG_DBG, 64'd0);

    // Forwarding: x7 = 0x11, then in-flight 0x22 on both read ports
    drive(5'd7, 32'h11, 5'd0, 5'd0, 5'd7);
    expect_at(0, SIG_DBG, 64'd0);
    drive(5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
    expect_at(0, SIG_RS1, 64'h22);
    expect_at(0, SIG_RS2, 64'h22);
    expect_at(0, SIG_DBG, 64'h11);
    expect_at(1, SIG_DBG, 64'h22);
    drive(5'd0, 32'h0, 5'd7, 5'd5, 5'd7);
    expect_at(0, SIG_RS1, 64'h22);
    expect_at(0, SIG_RS2, 64'hDEADBEEF);

    // Back-to-back commits
    drive(5'd3, 32'd1, 5'd3, 5'd7, 5'd3);
    expect_at(0, SIG_RS1, 64'd1);
    expect_at(0, SIG_RS2, 64'h22);
    expect_trace(1'b1, 5'd3, 32'd1);
    drive(5'd3, 32'd2, 5'd3, 5'd4, 5'd3);
    expect_at(0, SIG_RS1, 64'd2);
    expect_at(0, SIG_RS2, 64'd0);
    expect_at(0, SIG_DBG, 64'd1);
    expect_trace(1'b1, 5'd3, 32'd2);
    drive(5'd4, 32'd3, 5'd3, 5'd4, 5'd4);
    expect_at(0, SIG_RS1, 64'd2);
    expect_at(0, SIG_RS2, 64'd3);
    expect_at(0, SIG_DBG, 64'd0);
    expect_trace(1'b1, 5'd4, 32'd3);
    drive(5'd0, 32'h0, 5'd3, 5'd4, 5'd3);
    expect_at(0, SIG_RS1, 64'd2);
    expect_at(0, SIG_RS2, 64'd3);
    expect_at(0, SIG_DBG, 64'd2);

    // Trace hold: one commit then 4 idle cycles
    drive(5'd9, 32'hA5, 5'd9, 5'd3, 5'd4);
    expect_at(0, SIG_RS1, 64'hA5);
    expect_at(0, SIG_RS2, 64'd2);
    expect_at(0, SIG_DBG, 64'd3);
    expect_trace(1'b1, 5'd9, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 32'hFFFF0000 + i, 5'd9, 5'd0, 5'd9);
      expect_at(0, SIG_RS1, 64'hA5);
      expect_at(0, SIG_DBG, 64'hA5);
      expect_trace(1'b0, 5'd9, 32'hA5);
    end

    // Counter mix: 10 edges with 6 commits (checked via the running model)
    for (int i = 0; i < 10; i++) begin
      drive((i % 5 < 3) ? 5'(i + 10) : 5'd0, 32'(i * 3), 5'd0, 5'd0, 5'd0);
    end
    drive(5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

`ifdef WB_PERF_CNT_EN
    // Counter wrap from 2^64-1 to 0
    @(negedge clk);
    force dut.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.r_cycle;
    m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
`endif

    drive(5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      checks = checks + sbq.size();
      failures = failures + sbq.size();
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=cyc%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
